// File: rtl/shift_sequencer.sv
// Serial shift / bit-field-extract engine shared by two requesters.
// Round-robin arbitration in IDLE, then a left phase and a right phase, one bit per cycle.
module shift_sequencer #(
  parameter int DATA_W = 16,
  parameter int AMT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [AMT_W-1:0]  req0_sl,
  input  logic [AMT_W-1:0]  req0_sr,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [AMT_W-1:0]  req1_sl,
  input  logic [AMT_W-1:0]  req1_sr,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_tag,
  output logic              busy
);

  // state | meaning
  // IDLE  | waiting for a command, arbitration active
  // LEFT  | shifting left one bit per cycle, l_cnt steps remain
  // RIGHT | shifting right one bit per cycle, r_cnt steps remain
  // DONE  | result held on res_* until res_ready
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, DONE} state_t;

  localparam logic [1:0] OP_SHL = 2'b01;
  localparam logic [1:0] OP_SHR = 2'b10;
  localparam logic [1:0] OP_BFE = 2'b11;

  state_t state, state_nxt;

  logic              last_grant;
  logic [DATA_W-1:0] data_q;
  logic [AMT_W-1:0]  l_cnt;
  logic [AMT_W-1:0]  r_cnt;
  logic              tag_q;

  logic              grant0, grant1;
  logic              accept;
  logic [1:0]        sel_op;
  logic [DATA_W-1:0] sel_data;
  logic [AMT_W-1:0]  sel_sl, sel_sr;
  logic [AMT_W-1:0]  l_new, r_new;

  // last_grant=1 means req1 won last time, so req0 is favoured on a tie
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant);
    grant1 = req1_valid & (~req0_valid | ~last_grant);
  end

  // Readies are forced low while reset is asserted
  assign req0_ready = rst_n & (state == IDLE) & grant0;
  assign req1_ready = rst_n & (state == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    sel_op   = req1_ready ? req1_op   : req0_op;
    sel_data = req1_ready ? req1_data : req0_data;
    sel_sl   = req1_ready ? req1_sl   : req0_sl;
    sel_sr   = req1_ready ? req1_sr   : req0_sr;
  end

  // BFE right count is the truncated sum of both amounts
  always_comb begin
    l_new = '0;
    r_new = '0;
    case (sel_op)
      OP_SHL: l_new = sel_sl;
      OP_SHR: r_new = sel_sr;
      OP_BFE: begin
        l_new = sel_sl;
        r_new = sel_sl + sel_sr;
      end
      default: begin
        l_new = '0;
        r_new = '0;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (l_new != '0)      state_nxt = LEFT;
          else if (r_new != '0) state_nxt = RIGHT;
          else                  state_nxt = DONE;
        end
      end
      LEFT: begin
        if (l_cnt == AMT_W'(1)) state_nxt = (r_cnt != '0) ? RIGHT : DONE;
      end
      RIGHT: begin
        if (r_cnt == AMT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      data_q     <= '0;
      l_cnt      <= '0;
      r_cnt      <= '0;
      tag_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_q     <= sel_data;
            l_cnt      <= l_new;
            r_cnt      <= r_new;
            tag_q      <= req1_ready;
            last_grant <= req1_ready;
          end
        end
        LEFT: begin
          data_q <= data_q << 1;
          l_cnt  <= l_cnt - AMT_W'(1);
        end
        RIGHT: begin
          data_q <= data_q >> 1;
          r_cnt  <= r_cnt - AMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign res_valid = (state == DONE);
  assign res_data  = data_q;
  assign res_tag   = tag_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: vector table plus arbitration, backpressure and reset sequences.
module tb_shift_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [15:0] req0_data, req1_data;
  logic [3:0]  req0_sl, req0_sr, req1_sl, req1_sr;
  logic        res_valid, res_ready, res_tag, busy;
  logic [15:0] res_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.DATA_W(16), .AMT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_data(req0_data), .req0_sl(req0_sl), .req0_sr(req0_sr),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_data(req1_data), .req1_sl(req1_sl), .req1_sr(req1_sr),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .busy(busy)
  );

  typedef struct {
    logic        port;
    logic [1:0]  op;
    logic [15:0] data;
    logic [3:0]  sl;
    logic [3:0]  sr;
    logic [15:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_cmd(input logic port, input logic [1:0] op, input logic [15:0] d,
                           input logic [3:0] sl, input logic [3:0] sr, output bit ok);
    @(negedge clk);
    if (!port) begin
      req0_valid = 1'b1; req0_op = op; req0_data = d; req0_sl = sl; req0_sr = sr;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_data = d; req1_sl = sl; req1_sr = sr;
    end
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (port ? req1_ready : req0_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      chk("accept_timeout", 0, 1);
    end
    if (!port) req0_valid = 1'b0;
    else       req1_valid = 1'b0;
  endtask

  // Counts rising edges from the accept edge (inclusive) until res_valid is seen
  task automatic wait_result(output int lat, output bit ok);
    lat = 1;
    ok = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
      lat++;
    end
    if (!ok) chk("result_timeout", 0, 1);
  endtask

  task automatic finish_cmd();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("idle_after_handshake", {busy, res_valid}, 2'b00);
  endtask

  task automatic run_cmd(input string name, input logic port, input logic [1:0] op,
                         input logic [15:0] d, input logic [3:0] sl, input logic [3:0] sr,
                         input logic [15:0] exp_data, input int exp_lat);
    bit ok;
    int lat;
    start_cmd(port, op, d, sl, sr, ok);
    if (ok) begin
      wait_result(lat, ok);
      if (ok) begin
        chk({name, "_data"}, res_data, exp_data);
        chk({name, "_tag"}, res_tag, port);
        chk({name, "_lat"}, lat, exp_lat);
        finish_cmd();
      end
    end
  endtask

  initial begin
    bit ok;
    bit stable;
    int lat;
    int g;
    logic grants[4];

    vecs[0] = '{1'b0, 2'b01, 16'h00F3, 4'd4,  4'd0, 16'h0F30, 5};
    vecs[1] = '{1'b1, 2'b10, 16'h8001, 4'd0,  4'd15, 16'h0001, 16};
    vecs[2] = '{1'b0, 2'b00, 16'hABCD, 4'd0,  4'd0, 16'hABCD, 1};
    vecs[3] = '{1'b1, 2'b11, 16'h1234, 4'd4,  4'd4, 16'h0023, 13};
    vecs[4] = '{1'b0, 2'b11, 16'h1234, 4'd12, 4'd8, 16'h0400, 17};
    vecs[5] = '{1'b1, 2'b11, 16'h0001, 4'd15, 4'd0, 16'h0001, 31};
    vecs[6] = '{1'b1, 2'b01, 16'hFFFF, 4'd0,  4'd0, 16'hFFFF, 1};
    vecs[7] = '{1'b0, 2'b10, 16'h8000, 4'd0,  4'd1, 16'h4000, 2};
    vecs[8] = '{1'b1, 2'b00, 16'h5A5A, 4'd3,  4'd5, 16'h5A5A, 1};
    vecs[9] = '{1'b0, 2'b01, 16'h0001, 4'd1,  4'd7, 16'h0002, 2};

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    req0_op = 2'b00; req1_op = 2'b00; req0_data = '0; req1_data = '0;
    req0_sl = '0; req0_sr = '0; req1_sl = '0; req1_sr = '0;
    #3;
    chk("reset_outputs", {res_valid, res_tag, busy, req0_ready, req1_ready, res_data}, 21'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_cmd($sformatf("v%0d", i), vecs[i].port, vecs[i].op, vecs[i].data,
              vecs[i].sl, vecs[i].sr, vecs[i].exp_data, vecs[i].exp_lat);

    // After a req1-only command, a tie goes to req0; dropping valid leaves no trace
    run_cmd("req1_only", 1'b1, 2'b00, 16'h0F0F, 4'd0, 4'd0, 16'h0F0F, 1);
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("tie_after_req1", {req0_ready, req1_ready}, 2'b10);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("dropped_not_accepted", {busy, res_valid}, 2'b00);

    // Continuous contention with PASS commands alternates grants
    req0_op = 2'b00; req0_data = 16'h1111; req1_op = 2'b00; req1_data = 16'h2222;
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    g = 0;
    for (int c = 0; c < 40 && g < 4; c++) begin
      #1;
      if (req0_ready && req1_ready) chk("both_ready", 1, 0);
      if (req0_ready || req1_ready) begin
        grants[g] = req1_ready;
        g++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    res_ready = 1'b0;
    chk("arb_grant_count", g, 4);
    for (int k = 0; k < g; k++) chk($sformatf("arb_grant%0d", k), grants[k], k % 2);
    @(negedge clk);
    chk("arb_idle", {busy, res_valid}, 2'b00);

    // Backpressure: result and status hold, contending requesters stay blocked
    start_cmd(1'b0, 2'b01, 16'h00F3, 4'd4, 4'd0, ok);
    if (ok) begin
      wait_result(lat, ok);
      if (ok) begin
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
          #1;
          chk($sformatf("hold%0d", c),
              {res_valid, busy, req0_ready, req1_ready, res_tag, res_data},
              {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0F30});
          @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        finish_cmd();
      end
    end

    // Async reset mid-LEFT discards the in-flight command
    start_cmd(1'b0, 2'b01, 16'h00F3, 4'd8, 4'd0, ok);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2;
    req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {res_valid, res_tag, busy, req0_ready, req1_ready, res_data}, 21'h0);
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (res_valid || busy) stable = 1'b0;
    end
    chk("no_stale_result", stable, 1);
    run_cmd("post_reset", 1'b1, 2'b01, 16'h0003, 4'd2, 4'd0, 16'h000C, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
